control_multi: RTL and testbench
================================

CONTROL_MULTI -- requirements
Module: control_multi

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset. Ports are iCLK and iRST; iRST=0 resets on the rising edge of iCLK.
REQ-002 iCLK  in  1  system clock; all state changes on its rising edge.
REQ-003 iRST  in  1  synchronous active-low reset.
REQ-004 iOp  in  7  opcode field of the instruction register; stable from DECODE until the return to FETCH.
REQ-005 iMemReady  in  1  memory completion strobe for the current access (used only when MULTI_MEMWAIT_EN is defined).
REQ-006 oPCWrite, oPCWriteCond, oIRWrite, oMemRead, oMemWrite, oRegWrite, oIorD  out  1 each  datapath strobes and selects.
REQ-007 oALUSrcA  out  2  ALU A source: 00=PC, 01=reg A, 10=oldPC.
REQ-008 oALUSrcB  out  2  ALU B source: 00=reg B, 01=const 4, 10=imm.
REQ-009 oALUop  out  2  ALU operation: 00=add, 01=branch compare, 10=funct-decoded.
REQ-010 oPCSource  out  2  next-PC source: 00=ALU result, 01=ALUOut register, 10=ALU result with bit0 cleared.
REQ-011 oMemtoReg  out  2  register write data: 00=ALUOut, 01=MDR, 10=PC (link), 11=imm.
REQ-012 oState  out  4  current state encoding; oIllegal  out  1  one-cycle pulse on an unknown opcode.

Function
REQ-013 The block SHALL be a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12. Codes 13-15 are unreachable and SHALL transition to FETCH.
REQ-014 FETCH SHALL assert MemRead=1, IorD=0, A=00, B=01, ALUop=00, PCSource=00. IRWrite and PCWrite SHALL be asserted only in the exit cycle. FETCH then goes to DECODE.
REQ-015 DECODE SHALL set A=10, B=10, ALUop=00, so that ALUOut holds the branch/JAL target. DECODE then goes to the next state by iOp:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEMADR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - any other value -> FETCH, with oIllegal=1 for that one DECODE cycle.
REQ-016 MEMADR SHALL set A=01, B=10, ALUop=00, then go to MEMREAD if iOp=0000011, else to MEMWRITE.
REQ-017 MEMREAD SHALL assert MemRead=1, IorD=1, then go to MEMWB. MEMWB SHALL assert RegWrite=1, MemtoReg=01, then go to FETCH.
REQ-018 MEMWRITE SHALL assert MemWrite=1, IorD=1 and go to FETCH on exit.
REQ-019 EXEC_R SHALL set A=01, B=00, ALUop=10. EXEC_I SHALL set A=01, B=10, ALUop=10. Both go to ALUWB. ALUWB SHALL assert RegWrite=1, MemtoReg=00, then go to FETCH.
REQ-020 BRANCH SHALL set A=01, B=00, ALUop=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-021 JAL SHALL assert RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=01, then go to FETCH.
REQ-022 JALR SHALL set A=01, B=10, ALUop=00 and assert RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=10, then go to FETCH.
REQ-023 LUI SHALL assert RegWrite=1, MemtoReg=11, then go to FETCH.
REQ-024 Signals not listed for a state SHALL be 0.
REQ-025 Instruction latency without wait states SHALL be, counted in cycles from FETCH entry to the next FETCH entry:
  - load: 5
  - R-type, I-type, store: 4
  - branch, JAL, JALR, LUI: 3
  - illegal opcode: 2
REQ-026 At most one of MemRead/MemWrite, and at most one of PCWrite/PCWriteCond, SHALL be asserted in any cycle.

Reset
REQ-027 While iRST=0, the block SHALL hold state=FETCH and drive oState=0, oIllegal=0, and all 1-bit strobes to 0. All 2-bit selects SHALL be 00.
REQ-028 After iRST returns to 1, the first cycle SHALL be a normal FETCH cycle.
REQ-029 Reset asserted mid-instruction SHALL abandon that instruction. No write strobe may be asserted in the reset cycle or the cycle it takes effect.

Configuration
REQ-030 The macro MULTI_MEMWAIT_EN SHALL select how the memory states exit.
  - Defined: FETCH, MEMREAD and MEMWRITE stay in their state while iMemReady=0 and hold their outputs with IRWrite=PCWrite=0. They exit in the cycle iMemReady=1; IRWrite and PCWrite pulse only in that cycle.
  - Undefined: iMemReady SHALL be ignored, every memory state lasts exactly one cycle, and FETCH asserts IRWrite and PCWrite in its single cycle.

Verification
REQ-031 Without the macro, reset then iOp=0110011: oState sequence 0,1,6,8,0; RegWrite=1 only in state 8; PCWrite=1 only in the first cycle.
REQ-032 Load iOp=0000011: sequence 0,1,2,3,4,0. MemRead=1/IorD=1 in state 3; RegWrite=1 with MemtoReg=01 in state 4.
REQ-033 iOp=1100111 (JALR): sequence 0,1,11,0. In state 11, PCWrite=1, PCSource=10, RegWrite=1, MemtoReg=10.
REQ-034 iOp=1111111: sequence 0,1,0; oIllegal=1 in exactly the DECODE cycle; no RegWrite, MemWrite or PCWrite in state 1.
REQ-035 With the macro, store iOp=0100011 and iMemReady=0 for 3 cycles in MEMWRITE: state 5 held 4 cycles with MemWrite=1, then state 0. Fetch with a 2-cycle wait: IRWrite=1 in the third FETCH cycle only.
REQ-036 iRST=0 asserted during state 8: next state 0 with RegWrite=0. Reset held 2 cycles, then release: FETCH resumes normally.

Source files
------------

// File: rtl/control_multi.sv
// Multi-cycle RISC-V control FSM: fetch, decode, memory, ALU, branch, jump, LUI.
// Optional MULTI_MEMWAIT_EN: memory states wait for iMemReady before exiting.
module control_multi (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [6:0] iOp,
  input  logic       iMemReady,
  output logic       oPCWrite,
  output logic       oPCWriteCond,
  output logic       oIRWrite,
  output logic       oMemRead,
  output logic       oMemWrite,
  output logic       oRegWrite,
  output logic       oIorD,
  output logic [1:0] oALUSrcA,
  output logic [1:0] oALUSrcB,
  output logic [1:0] oALUop,
  output logic [1:0] oPCSource,
  output logic [1:0] oMemtoReg,
  output logic [3:0] oState,
  output logic       oIllegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LUI      = 4'd12
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t state;
  logic   mem_ok;

`ifdef MULTI_MEMWAIT_EN
  assign mem_ok = iMemReady;
`else
  logic unused_ready;
  assign unused_ready = iMemReady;
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:
          if (mem_ok) state <= DECODE;
        DECODE:
          case (iOp)
            OP_R:     state <= EXEC_R;
            OP_I:     state <= EXEC_I;
            OP_LOAD,
            OP_STORE: state <= MEMADR;
            OP_BR:    state <= BRANCH;
            OP_JAL:   state <= JAL;
            OP_JALR:  state <= JALR;
            OP_LUI:   state <= LUI;
            default:  state <= FETCH;
          endcase
        MEMADR:
          state <= (iOp == OP_LOAD) ? MEMREAD : MEMWRITE;
        MEMREAD:
          if (mem_ok) state <= MEMWB;
        MEMWRITE:
          if (mem_ok) state <= FETCH;
        EXEC_R, EXEC_I:
          state <= ALUWB;
        default:
          state <= FETCH;
      endcase
    end
  end

  // Outputs are forced quiet while reset is low so no write escapes the reset cycle.
  always_comb begin
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oIRWrite     = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oRegWrite    = 1'b0;
    oIorD        = 1'b0;
    oALUSrcA     = 2'b00;
    oALUSrcB     = 2'b00;
    oALUop       = 2'b00;
    oPCSource    = 2'b00;
    oMemtoReg    = 2'b00;
    oIllegal     = 1'b0;
    if (iRST) begin
      case (state)
        FETCH: begin
          oMemRead = 1'b1;
          oALUSrcB = 2'b01;
          oIRWrite = mem_ok;
          oPCWrite = mem_ok;
        end
        DECODE: begin
          oALUSrcA = 2'b10;
          oALUSrcB = 2'b10;
          oIllegal = !(iOp inside {OP_R, OP_I, OP_LOAD, OP_STORE,
                                   OP_BR, OP_JAL, OP_JALR, OP_LUI});
        end
        MEMADR: begin
          oALUSrcA = 2'b01;
          oALUSrcB = 2'b10;
        end
        MEMREAD: begin
          oMemRead = 1'b1;
          oIorD    = 1'b1;
        end
        MEMWB: begin
          oRegWrite = 1'b1;
          oMemtoReg = 2'b01;
        end
        MEMWRITE: begin
          oMemWrite = 1'b1;
          oIorD     = 1'b1;
        end
        EXEC_R: begin
          oALUSrcA = 2'b01;
          oALUop   = 2'b10;
        end
        EXEC_I: begin
          oALUSrcA = 2'b01;
          oALUSrcB = 2'b10;
          oALUop   = 2'b10;
        end
        ALUWB:
          oRegWrite = 1'b1;
        BRANCH: begin
          oALUSrcA     = 2'b01;
          oALUop       = 2'b01;
          oPCWriteCond = 1'b1;
          oPCSource    = 2'b01;
        end
        JAL: begin
          oRegWrite = 1'b1;
          oMemtoReg = 2'b10;
          oPCWrite  = 1'b1;
          oPCSource = 2'b01;
        end
        JALR: begin
          oALUSrcA  = 2'b01;
          oALUSrcB  = 2'b10;
          oRegWrite = 1'b1;
          oMemtoReg = 2'b10;
          oPCWrite  = 1'b1;
          oPCSource = 2'b10;
        end
        LUI: begin
          oRegWrite = 1'b1;
          oMemtoReg = 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign oState = iRST ? state : 4'd0;

endmodule

// File: tb/tb_control_multi.sv
// Randomized bench for control_multi against an instruction-level model.
// Build with MULTI_MEMWAIT_EN defined to exercise memory wait states.
module tb_control_multi;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b0;
  logic [6:0] iOp = 7'd0;
  logic       iMemReady = 1'b0;
  logic       oPCWrite, oPCWriteCond, oIRWrite, oMemRead;
  logic       oMemWrite, oRegWrite, oIorD, oIllegal;
  logic [1:0] oALUSrcA, oALUSrcB, oALUop, oPCSource, oMemtoReg;
  logic [3:0] oState;

  int checks = 0;
  int failures = 0;

`ifdef MULTI_MEMWAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  control_multi dut (
    .iCLK(iCLK), .iRST(iRST), .iOp(iOp), .iMemReady(iMemReady),
    .oPCWrite(oPCWrite), .oPCWriteCond(oPCWriteCond),
    .oIRWrite(oIRWrite), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
    .oRegWrite(oRegWrite), .oIorD(oIorD), .oALUSrcA(oALUSrcA),
    .oALUSrcB(oALUSrcB), .oALUop(oALUop), .oPCSource(oPCSource),
    .oMemtoReg(oMemtoReg), .oState(oState), .oIllegal(oIllegal)
  );

  always #5 iCLK = ~iCLK;

  logic [6:0] legal_ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011,
    7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_illegal(input logic [6:0] op);
    return !(op inside {legal_ops});
  endfunction

  // States visited after FETCH, in order, for one instruction.
  function automatic void build_path(input logic [6:0] op, output int p[$]);
    p = {};
    p.push_back(1);
    case (op)
      7'b0110011: begin p.push_back(6); p.push_back(8); end
      7'b0010011: begin p.push_back(7); p.push_back(8); end
      7'b0000011: begin p.push_back(2); p.push_back(3); p.push_back(4); end
      7'b0100011: begin p.push_back(2); p.push_back(5); end
      7'b1100011: p.push_back(9);
      7'b1101111: p.push_back(10);
      7'b1100111: p.push_back(11);
      7'b0110111: p.push_back(12);
      default: ;
    endcase
  endfunction

  function automatic int latency(input logic [6:0] op);
    if (op == 7'b0000011) return 5;
    if (op inside {7'b0110011, 7'b0010011, 7'b0100011}) return 4;
    if (op inside {7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111}) return 3;
    return 2;
  endfunction

  // {PCWrite,PCWriteCond,IRWrite,MemRead,MemWrite,RegWrite,IorD,A,B,ALUop,PCSrc,MemtoReg,Illegal}
  function automatic logic [17:0] expect_out(input int st, input logic [6:0] op,
                                             input logic rdy);
    logic go;
    go = !WAIT_EN || rdy;
    case (st)
      0:  return {go, 1'b0, go, 4'b1000, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
      1:  return {7'b0000000, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, is_illegal(op)};
      2:  return {7'b0000000, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0};
      3:  return {7'b0001001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      4:  return {7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
      5:  return {7'b0000101, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      6:  return {7'b0000000, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
      7:  return {7'b0000000, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0};
      8:  return {7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      9:  return {7'b0100000, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
      10: return {7'b1000010, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 1'b0};
      11: return {7'b1000010, 2'b01, 2'b10, 2'b00, 2'b10, 2'b10, 1'b0};
      12: return {7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0};
      default: return 18'h3ffff;
    endcase
  endfunction

  function automatic logic [17:0] observed();
    return {oPCWrite, oPCWriteCond, oIRWrite, oMemRead, oMemWrite,
            oRegWrite, oIorD, oALUSrcA, oALUSrcB, oALUop, oPCSource,
            oMemtoReg, oIllegal};
  endfunction

  task automatic check_quiet(input string tag);
    @(negedge iCLK);
    chk({tag, "_state"}, 32'(oState), 32'd0);
    chk({tag, "_outs"}, 32'(observed()), 32'd0);
  endtask

  // Runs one instruction from a FETCH cycle; abort_at>=0 asserts reset
  // at that cycle index and holds it for two cycles.
  task automatic run(input logic [6:0] op, input int abort_at);
    int p[$];
    int st, idx, cyc, waits, streak;
    logic rdy;
    bit done;
    build_path(op, p);
    st = 0; idx = 0; cyc = 0; waits = 0; streak = 0; done = 0;
    for (int g = 0; g < 60; g++) begin
      rdy = (streak >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      iMemReady = rdy;
      iOp = (st == 0) ? 7'($urandom) : op;
      if (cyc == abort_at) begin
        iRST = 1'b0;
        check_quiet("rst_cycle");
        @(posedge iCLK); #1;
        check_quiet("rst_hold");
        @(posedge iCLK); #1;
        iRST = 1'b1;
        return;
      end
      @(negedge iCLK);
      chk($sformatf("state_op%02h_c%0d", op, cyc), 32'(oState), 32'(st));
      chk($sformatf("outs_op%02h_s%0d", op, st), 32'(observed()),
          32'(expect_out(st, op, rdy)));
      cyc++;
      if (WAIT_EN && (st inside {0, 3, 5}) && !rdy) begin
        streak++;
        waits++;
      end else begin
        streak = 0;
        if (idx < p.size()) st = p[idx++];
        else done = 1;
      end
      @(posedge iCLK); #1;
      if (done) begin
        chk($sformatf("latency_op%02h", op), 32'(cyc),
            32'(latency(op) + waits));
        return;
      end
    end
    chk("cycle_budget", 32'(cyc), 32'hffff_ffff);
  endtask

  initial begin
    iRST = 1'b0;
    @(posedge iCLK); #1;
    check_quiet("reset");
    @(posedge iCLK); #1;
    check_quiet("reset2");
    @(posedge iCLK); #1;
    iRST = 1'b1;
    run(7'b0110011, -1);
    run(7'b0000011, -1);
    run(7'b1100111, -1);
    run(7'b1111111, -1);
    run(7'b0100011, -1);
    run(7'b0110011, 3);
    run(7'b0110011, -1);
    run(7'b1100011, -1);
    run(7'b1101111, -1);
    run(7'b0110111, -1);
    run(7'b0010011, -1);
    for (int n = 0; n < 80; n++) begin
      logic [6:0] op;
      int ab;
      op = ($urandom_range(0, 3) == 0) ? 7'($urandom)
                                        : legal_ops[$urandom_range(0, 7)];
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      run(op, ab);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
